// File: rtl/tier2_ram_arbiter_pkg.sv
// Shared definitions for the Tier-2 codeblock buffer RAM arbiter.
package tier2_pkg;

    localparam int WORD_WIDTH_DEF = 18;
    localparam int ADDR_WIDTH_DEF = 14;
    localparam int WAIT_W         = 8;

    // Identifies which requester owns the read currently travelling through the RAM.
    typedef enum logic [1:0] {
        TAG_NONE = 2'd0,
        TAG_RD   = 2'd1,
        TAG_HST  = 2'd2
    } tag_t;

endpackage

// File: rtl/tier2_ram_arbiter_if.sv
// Requester and RAM-side bus of the Tier-2 RAM arbiter.
interface tier2_ram_arbiter_if
    import tier2_pkg::*;
#(
    parameter int WORD_WIDTH = WORD_WIDTH_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
);
    logic                  wr_req;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [WORD_WIDTH-1:0] wr_data;
    logic                  wr_gnt;
    logic                  rd_req;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic                  rd_gnt;
    logic [WORD_WIDTH-1:0] rd_data;
    logic                  rd_valid;
    logic                  hst_req;
    logic [ADDR_WIDTH-1:0] hst_addr;
    logic                  hst_gnt;
    logic [WORD_WIDTH-1:0] hst_data;
    logic                  hst_valid;
    logic                  ram_en;
    logic                  ram_we;
    logic [ADDR_WIDTH-1:0] ram_addr;
    logic [WORD_WIDTH-1:0] ram_wdata;
    logic [WORD_WIDTH-1:0] ram_rdata;

    // Requesters and the RAM macro.
    modport master (
        output wr_req, wr_addr, wr_data, rd_req, rd_addr, hst_req, hst_addr, ram_rdata,
        input  wr_gnt, rd_gnt, rd_data, rd_valid, hst_gnt, hst_data, hst_valid,
        input  ram_en, ram_we, ram_addr, ram_wdata
    );

    // The arbiter.
    modport slave (
        input  wr_req, wr_addr, wr_data, rd_req, rd_addr, hst_req, hst_addr, ram_rdata,
        output wr_gnt, rd_gnt, rd_data, rd_valid, hst_gnt, hst_data, hst_valid,
        output ram_en, ram_we, ram_addr, ram_wdata
    );

endinterface

// File: rtl/tier2_ram_arbiter_age.sv
// Per-requester saturating wait counter; flags starvation once it reaches MAX_WAIT.
module tier2_arb_age
    import tier2_pkg::*;
#(
    parameter int MAX_WAIT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic req,
    input  logic gnt,
    output logic starved
);

    localparam logic [WAIT_W-1:0] SAT = WAIT_W'(MAX_WAIT);

    logic [WAIT_W-1:0] wait_cnt;

    // Count consecutive lost cycles; a grant, a dropped request or a flush restarts the count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wait_cnt <= '0;
        end else if (clear || !req || gnt) begin
            wait_cnt <= '0;
        end else if (wait_cnt != SAT) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    assign starved = (wait_cnt == SAT);

endmodule

// File: rtl/tier2_ram_arbiter.sv
// Single-port arbiter for the Tier-2 codeblock buffer RAM: writer, codestream reader, host.
module tier2_ram_arbiter
    import tier2_pkg::*;
#(
    parameter int WORD_WIDTH = WORD_WIDTH_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int MAX_WAIT   = 15
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clear,
    tier2_ram_arbiter_if.slave  bus
);

    logic                  rd_starved;
    logic                  hst_starved;
    logic                  wr_win;
    logic                  rd_win;
    logic                  hst_win;
    logic                  ram_en_p1;
    logic                  ram_we_p1;
    logic [ADDR_WIDTH-1:0] ram_addr_p1;
    logic [WORD_WIDTH-1:0] ram_wdata_p1;
    tag_t                  tag_p1;
    tag_t                  tag_p2;
    logic [WORD_WIDTH-1:0] rd_hold;
    logic [WORD_WIDTH-1:0] hst_hold;

    tier2_arb_age #(.MAX_WAIT(MAX_WAIT)) u_rd_age (
        .clk     (clk),
        .rst     (rst),
        .clear   (clear),
        .req     (bus.rd_req),
        .gnt     (rd_win),
        .starved (rd_starved)
    );

    tier2_arb_age #(.MAX_WAIT(MAX_WAIT)) u_hst_age (
        .clk     (clk),
        .rst     (rst),
        .clear   (clear),
        .req     (bus.hst_req),
        .gnt     (hst_win),
        .starved (hst_starved)
    );

    // Pick one winner: starved rd, then starved hst, then base order wr > rd > hst.
    always_comb begin
        wr_win  = 1'b0;
        rd_win  = 1'b0;
        hst_win = 1'b0;
        if (rst && !clear) begin
            if (bus.rd_req && rd_starved)        rd_win  = 1'b1;
            else if (bus.hst_req && hst_starved) hst_win = 1'b1;
            else if (bus.wr_req)                 wr_win  = 1'b1;
            else if (bus.rd_req)                 rd_win  = 1'b1;
            else if (bus.hst_req)                hst_win = 1'b1;
        end
    end

    assign bus.wr_gnt  = wr_win;
    assign bus.rd_gnt  = rd_win;
    assign bus.hst_gnt = hst_win;

    // Stage p1: launch the granted access onto the RAM port and tag reads with their owner.
    // Stage p2: the tag follows the RAM's one-cycle read latency.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ram_en_p1    <= 1'b0;
            ram_we_p1    <= 1'b0;
            ram_addr_p1  <= '0;
            ram_wdata_p1 <= '0;
            tag_p1       <= TAG_NONE;
            tag_p2       <= TAG_NONE;
        end else if (clear) begin
            ram_en_p1 <= 1'b0;
            ram_we_p1 <= 1'b0;
            tag_p1    <= TAG_NONE;
            tag_p2    <= TAG_NONE;
        end else begin
            ram_en_p1 <= wr_win | rd_win | hst_win;
            ram_we_p1 <= wr_win;
            if (wr_win) begin
                ram_addr_p1  <= bus.wr_addr;
                ram_wdata_p1 <= bus.wr_data;
            end else if (rd_win) begin
                ram_addr_p1  <= bus.rd_addr;
            end else if (hst_win) begin
                ram_addr_p1  <= bus.hst_addr;
            end
            tag_p1 <= rd_win ? TAG_RD : (hst_win ? TAG_HST : TAG_NONE);
            tag_p2 <= tag_p1;
        end
    end

    // Remember the last word delivered to each reader so the data outputs hold between pulses.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_hold  <= '0;
            hst_hold <= '0;
        end else begin
            if (tag_p2 == TAG_RD)  rd_hold  <= bus.ram_rdata;
            if (tag_p2 == TAG_HST) hst_hold <= bus.ram_rdata;
        end
    end

    assign bus.ram_en    = ram_en_p1;
    assign bus.ram_we    = ram_we_p1;
    assign bus.ram_addr  = ram_addr_p1;
    assign bus.ram_wdata = ram_wdata_p1;
    assign bus.rd_valid  = (tag_p2 == TAG_RD);
    assign bus.hst_valid = (tag_p2 == TAG_HST);
    assign bus.rd_data   = (tag_p2 == TAG_RD)  ? bus.ram_rdata : rd_hold;
    assign bus.hst_data  = (tag_p2 == TAG_HST) ? bus.ram_rdata : hst_hold;

endmodule

// File: tb/tb_tier2_ram_arbiter.sv
// Self-checking bench for tier2_ram_arbiter: directed scenarios plus randomized traffic.
`timescale 1ns/1ps
module tb_tier2_ram_arbiter;
    import tier2_pkg::*;

    localparam int WW = 18;
    localparam int AW = 14;
    localparam int MW = 4;

    logic clk   = 1'b0;
    logic rst   = 1'b0;
    logic clear = 1'b0;
    always #5 clk = ~clk;

    tier2_ram_arbiter_if #(.WORD_WIDTH(WW), .ADDR_WIDTH(AW)) bus ();

    tier2_ram_arbiter #(.WORD_WIDTH(WW), .ADDR_WIDTH(AW), .MAX_WAIT(MW)) dut (
        .clk   (clk),
        .rst   (rst),
        .clear (clear),
        .bus   (bus.slave)
    );

    int n_checks = 0;
    int n_err    = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // RAM macro: one-cycle read latency; address 0x10 is preloaded while in reset.
    bit [WW-1:0] ram_mem [0:(1<<AW)-1];
    always @(posedge clk) begin
        if (!rst) ram_mem[16] <= 18'h2ABCD;
        else if (bus.ram_en) begin
            if (bus.ram_we) ram_mem[bus.ram_addr] <= bus.ram_wdata;
            else            bus.ram_rdata <= ram_mem[bus.ram_addr];
        end
    end

    // Reference model: a grant list per cycle, a memory image and the reads in flight.
    bit [WW-1:0]   mdl_mem [0:(1<<AW)-1];
    int            w_rd, w_hst, g;
    logic          m_en, m_we;
    logic [AW-1:0] m_addr;
    logic [WW-1:0] m_wdata, m_d1, m_d2, m_rd_last, m_hst_last;
    int            m_t1, m_t2;

    always @(negedge clk) begin
        if (!rst) begin
            chk("rst_wr_gnt", bus.wr_gnt, 0);
            chk("rst_rd_gnt", bus.rd_gnt, 0);
            chk("rst_hst_gnt", bus.hst_gnt, 0);
            chk("rst_ram_en", bus.ram_en, 0);
            chk("rst_ram_we", bus.ram_we, 0);
            chk("rst_ram_addr", bus.ram_addr, 0);
            chk("rst_ram_wdata", bus.ram_wdata, 0);
            chk("rst_rd_valid", bus.rd_valid, 0);
            chk("rst_rd_data", bus.rd_data, 0);
            chk("rst_hst_valid", bus.hst_valid, 0);
            chk("rst_hst_data", bus.hst_data, 0);
            m_en = 0; m_we = 0; m_addr = '0; m_wdata = '0; m_t1 = 0; m_t2 = 0;
            m_d1 = '0; m_d2 = '0; m_rd_last = '0; m_hst_last = '0; w_rd = 0; w_hst = 0;
            mdl_mem[16] = 18'h2ABCD;
        end else begin
            if (m_en && m_we) mdl_mem[m_addr] = m_wdata;
            chk("ram_en", bus.ram_en, m_en);
            if (m_en) begin
                chk("ram_we", bus.ram_we, m_we);
                chk("ram_addr", bus.ram_addr, m_addr);
                if (m_we) chk("ram_wdata", bus.ram_wdata, m_wdata);
            end
            chk("rd_valid", bus.rd_valid, m_t2 == 1);
            chk("rd_data", bus.rd_data, (m_t2 == 1) ? m_d2 : m_rd_last);
            chk("hst_valid", bus.hst_valid, m_t2 == 2);
            chk("hst_data", bus.hst_data, (m_t2 == 2) ? m_d2 : m_hst_last);
            if (m_t2 == 1) m_rd_last = m_d2;
            if (m_t2 == 2) m_hst_last = m_d2;
            g = 0;
            if (!clear) begin
                if (bus.rd_req && w_rd >= MW)        g = 2;
                else if (bus.hst_req && w_hst >= MW) g = 3;
                else if (bus.wr_req)                 g = 1;
                else if (bus.rd_req)                 g = 2;
                else if (bus.hst_req)                g = 3;
            end
            chk("wr_gnt", bus.wr_gnt, g == 1);
            chk("rd_gnt", bus.rd_gnt, g == 2);
            chk("hst_gnt", bus.hst_gnt, g == 3);
            m_t2 = clear ? 0 : m_t1;
            m_d2 = m_d1;
            if (clear) begin
                m_en = 0; m_we = 0; m_t1 = 0; w_rd = 0; w_hst = 0;
            end else begin
                m_en = (g != 0);
                m_we = (g == 1);
                m_t1 = (g == 2) ? 1 : ((g == 3) ? 2 : 0);
                if (g == 1) begin m_addr = bus.wr_addr; m_wdata = bus.wr_data; end
                if (g == 2) begin m_addr = bus.rd_addr;  m_d1 = mdl_mem[bus.rd_addr];  end
                if (g == 3) begin m_addr = bus.hst_addr; m_d1 = mdl_mem[bus.hst_addr]; end
                w_rd  = (bus.rd_req && g != 2)  ? ((w_rd  < MW) ? w_rd + 1  : MW) : 0;
                w_hst = (bus.hst_req && g != 3) ? ((w_hst < MW) ? w_hst + 1 : MW) : 0;
            end
        end
    end

    // Stimulus
    logic g_w, g_r, g_h;
    logic d_w, d_r, d_h, d_c, d_rst;
    logic [AW-1:0] d_wa, d_ra, d_ha;
    logic [WW-1:0] d_wd;

    task automatic cyc(input logic rstv, input logic c,
                       input logic w, input logic [AW-1:0] wa, input logic [WW-1:0] wd,
                       input logic r, input logic [AW-1:0] ra,
                       input logic h, input logic [AW-1:0] ha);
        @(posedge clk);
        #1;
        rst = rstv; clear = c;
        bus.wr_req = w;  bus.wr_addr = wa; bus.wr_data = wd;
        bus.rd_req = r;  bus.rd_addr = ra;
        bus.hst_req = h; bus.hst_addr = ha;
        @(negedge clk);
        g_w = bus.wr_gnt; g_r = bus.rd_gnt; g_h = bus.hst_gnt;
    endtask

    task automatic idle(input logic rstv);
        cyc(rstv, 0, 0, '0, '0, 0, '0, 0, '0);
    endtask

    initial begin
        bus.wr_req = 0; bus.wr_addr = '0; bus.wr_data = '0;
        bus.rd_req = 0; bus.rd_addr = '0; bus.hst_req = 0; bus.hst_addr = '0;
        g_w = 0; g_r = 0; g_h = 0;
        repeat (3) idle(0);
        idle(1);

        // Single read of the preloaded word
        cyc(1, 0, 0, '0, '0, 1, 14'h0010, 0, '0);
        chk("t1_rd_gnt", bus.rd_gnt, 1);
        idle(1);
        chk("t1_ram_en", bus.ram_en, 1);
        chk("t1_ram_we", bus.ram_we, 0);
        chk("t1_ram_addr", bus.ram_addr, 14'h0010);
        idle(1);
        chk("t1_rd_valid", bus.rd_valid, 1);
        chk("t1_rd_data", bus.rd_data, 18'h2ABCD);
        chk("t1_hst_valid", bus.hst_valid, 0);

        // Write then read the same address
        cyc(1, 0, 1, 14'h0005, 18'h12345, 0, '0, 0, '0);
        chk("t2_wr_gnt", bus.wr_gnt, 1);
        cyc(1, 0, 0, '0, '0, 1, 14'h0005, 0, '0);
        chk("t2_rd_gnt", bus.rd_gnt, 1);
        idle(1);
        idle(1);
        chk("t2_rd_valid", bus.rd_valid, 1);
        chk("t2_rd_data", bus.rd_data, 18'h12345);

        // Three-way contention: the writer wins while the others age
        for (int i = 0; i < 3; i++) begin
            cyc(1, 0, 1, AW'(14'h0020 + i), WW'(i), 1, 14'h0010, 1, 14'h0005);
            chk("t3_wr_gnt", bus.wr_gnt, 1);
            chk("t3_rd_gnt", bus.rd_gnt, 0);
            chk("t3_hst_gnt", bus.hst_gnt, 0);
        end
        idle(1);

        // Starvation guard with MAX_WAIT=4: wr x4, rd, hst, wr
        for (int i = 0; i < 7; i++) begin
            cyc(1, 0, 1, AW'(14'h0100 + i), WW'(i), 1, 14'h0010, 1, 14'h0011);
            chk("t4_wr_gnt", bus.wr_gnt, (i < 4) || (i == 6));
            chk("t4_rd_gnt", bus.rd_gnt, i == 4);
            chk("t4_hst_gnt", bus.hst_gnt, i == 5);
        end
        idle(1);
        idle(1);

        // Clear during a read in flight, and clear beside live requests
        cyc(1, 0, 0, '0, '0, 1, 14'h0010, 0, '0);
        chk("t5_rd_gnt", bus.rd_gnt, 1);
        cyc(1, 1, 1, 14'h0030, 18'h1, 1, 14'h0010, 1, 14'h0010);
        chk("t5_clr_wr_gnt", bus.wr_gnt, 0);
        chk("t5_clr_rd_gnt", bus.rd_gnt, 0);
        chk("t5_clr_hst_gnt", bus.hst_gnt, 0);
        idle(1);
        chk("t5_rd_valid", bus.rd_valid, 0);
        chk("t5_ram_en", bus.ram_en, 0);

        // Asynchronous reset during back-to-back traffic
        cyc(1, 0, 1, 14'h0007, 18'h3, 0, '0, 0, '0);
        cyc(1, 0, 0, '0, '0, 1, 14'h0007, 0, '0);
        chk("t6_rd_gnt", bus.rd_gnt, 1);
        cyc(0, 0, 0, '0, '0, 1, 14'h0010, 1, 14'h0010);
        chk("t6_ram_en", bus.ram_en, 0);
        chk("t6_rd_gnt", bus.rd_gnt, 0);
        chk("t6_rd_valid", bus.rd_valid, 0);
        idle(0);
        idle(1);
        idle(1);
        chk("t6_rd_valid_after", bus.rd_valid, 0);
        chk("t6_hst_valid_after", bus.hst_valid, 0);

        // Randomized traffic; requests are held until granted
        for (int i = 0; i < 3000; i++) begin
            d_w = bus.wr_req; d_wa = bus.wr_addr; d_wd = bus.wr_data;
            d_r = bus.rd_req; d_ra = bus.rd_addr;
            d_h = bus.hst_req; d_ha = bus.hst_addr;
            if (!d_w || g_w) begin
                d_w = ($urandom_range(0, 99) < 55); d_wa = AW'($urandom_range(0, 31)); d_wd = WW'($urandom);
            end
            if (!d_r || g_r) begin
                d_r = ($urandom_range(0, 99) < 50); d_ra = AW'($urandom_range(0, 31));
            end
            if (!d_h || g_h) begin
                d_h = ($urandom_range(0, 99) < 40); d_ha = AW'($urandom_range(0, 31));
            end
            d_c   = ($urandom_range(0, 149) == 0);
            d_rst = ($urandom_range(0, 399) != 0);
            cyc(d_rst, d_c, d_w, d_wa, d_wd, d_r, d_ra, d_h, d_ha);
        end
        idle(1);
        idle(1);
        idle(1);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
